// File: rtl/io_bridge_port_b_pkg.sv
// rtl/io_bridge_port_b_pkg.sv - shared types and constants for the port-B I/O bridge
package io_bridge_port_b_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE_BTN,
        ST_READ,
        ST_DRAIN,
        ST_COMMIT
    } bridge_state_t;

    localparam logic [15:0] DEF_BTN_ADDR = 16'hFF00;
    localparam logic [15:0] DEF_OBJ_BASE = 16'hFF10;

    // Bit positions inside btn_raw / btn_stable
    localparam int BTN_P1_UP   = 0;
    localparam int BTN_P1_DOWN = 1;
    localparam int BTN_P2_UP   = 2;
    localparam int BTN_P2_DOWN = 3;

endpackage

// File: rtl/io_bridge_port_b_btn_debounce.sv
// rtl/io_bridge_port_b_btn_debounce.sv - single-bit 2-flop synchronizer plus debouncer
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_async,
    output logic btn_stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // Counter tracks consecutive cycles the synchronized input disagrees with the stable bit
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            cnt        <= '0;
            btn_stable <= 1'b0;
        end else begin
            sync_1 <= btn_async;
            sync_2 <= sync_1;
            if (sync_2 == btn_stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt        <= '0;
                btn_stable <= sync_2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/io_bridge_port_b.sv
// rtl/io_bridge_port_b.sv - per-frame button mailbox write and object block read over BRAM port B
module io_bridge_port_b
    import io_bridge_port_b_pkg::*;
#(
    parameter logic [15:0] BTN_ADDR        = DEF_BTN_ADDR,
    parameter logic [15:0] OBJ_BASE        = DEF_OBJ_BASE,
    parameter int          N_OBJ           = 4,
    parameter int          DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic [3:0]            btn_raw,
    input  logic [15:0]           q_b,
    output logic [15:0]           addr_b,
    output logic [15:0]           data_b,
    output logic                  we_b,
    output logic [16*N_OBJ-1:0]   obj_data,
    output logic                  upd_done,
    output logic                  busy,
    output logic                  overrun
);

    localparam int          IW   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_OBJ - 1);

    logic [3:0] btn_stable;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1_up (
        .clk(clk), .reset(reset), .btn_async(btn_raw[BTN_P1_UP]), .btn_stable(btn_stable[BTN_P1_UP])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1_down (
        .clk(clk), .reset(reset), .btn_async(btn_raw[BTN_P1_DOWN]), .btn_stable(btn_stable[BTN_P1_DOWN])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2_up (
        .clk(clk), .reset(reset), .btn_async(btn_raw[BTN_P2_UP]), .btn_stable(btn_stable[BTN_P2_UP])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2_down (
        .clk(clk), .reset(reset), .btn_async(btn_raw[BTN_P2_DOWN]), .btn_stable(btn_stable[BTN_P2_DOWN])
    );

    bridge_state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [15:0]   addr_n;
    logic [15:0]   data_n;
    logic          we_n;
    logic          rd_n;

    logic          rd_valid;
    logic [IW-1:0] rd_idx;
    logic          cap_valid;
    logic [IW-1:0] cap_idx;
    logic [15:0]   shadow [N_OBJ];

    assign busy    = (state != ST_IDLE);
    assign overrun = frame_tick && busy;

    // Next-state logic also computes the port-B values for the state being entered
    always_comb begin
        state_n = state;
        idx_n   = idx;
        addr_n  = '0;
        data_n  = '0;
        we_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_n = ST_WRITE_BTN;
                    addr_n  = BTN_ADDR;
                    data_n  = {12'b0, btn_stable};
                    we_n    = 1'b1;
                end
            end
            ST_WRITE_BTN: begin
                state_n = ST_READ;
                idx_n   = '0;
                addr_n  = OBJ_BASE;
            end
            ST_READ: begin
                if (idx == LAST) begin
                    state_n = ST_DRAIN;
                end else begin
                    idx_n  = idx + IW'(1);
                    addr_n = OBJ_BASE + 16'(idx) + 16'd1;
                end
            end
            ST_DRAIN:  state_n = ST_COMMIT;
            ST_COMMIT: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
        rd_n = (state_n == ST_READ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            addr_b    <= '0;
            data_b    <= '0;
            we_b      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_idx    <= '0;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            upd_done  <= 1'b0;
            obj_data  <= '0;
            for (int i = 0; i < N_OBJ; i++) shadow[i] <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            addr_b    <= addr_n;
            data_b    <= data_n;
            we_b      <= we_n;
            rd_valid  <= rd_n;
            rd_idx    <= idx_n;
            // read data returns one cycle after the address, so capture lags issue by one
            cap_valid <= rd_valid;
            cap_idx   <= rd_idx;
            if (cap_valid) shadow[cap_idx] <= q_b;
            upd_done  <= (state == ST_COMMIT);
            if (state == ST_COMMIT) begin
                for (int i = 0; i < N_OBJ; i++) obj_data[16*i +: 16] <= shadow[i];
            end
        end
    end

endmodule

// File: tb/tb_io_bridge_port_b.sv
// tb/tb_io_bridge_port_b.sv - directed self-checking bench for io_bridge_port_b
module tb_io_bridge_port_b;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        frame_tick_w;
    logic [3:0]  btn_raw;

    logic [15:0] q_b, addr_b, data_b;
    logic        we_b, upd_done, busy, overrun;
    logic [63:0] obj_data;

    logic [15:0] q_b_w, addr_b_w, data_b_w;
    logic        we_b_w, upd_done_w, busy_w, overrun_w;
    logic [63:0] obj_data_w;

    logic [15:0] mem   [0:65535];
    logic [15:0] mem_w [0:65535];

    int n_checks = 0;
    int n_errors = 0;

    int wr_cnt = 0;
    int we_any_cnt = 0;
    int upd_cnt = 0;
    int ovr_cnt = 0;
    logic [15:0] wr_last = 16'h0;

    always #5 clk = ~clk;

    io_bridge_port_b #(.N_OBJ(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_raw(btn_raw),
        .q_b(q_b), .addr_b(addr_b), .data_b(data_b), .we_b(we_b),
        .obj_data(obj_data), .upd_done(upd_done), .busy(busy), .overrun(overrun)
    );

    io_bridge_port_b #(.OBJ_BASE(16'hFFFE), .N_OBJ(4), .DEBOUNCE_CYCLES(4)) dut_w (
        .clk(clk), .reset(reset), .frame_tick(frame_tick_w), .btn_raw(btn_raw),
        .q_b(q_b_w), .addr_b(addr_b_w), .data_b(data_b_w), .we_b(we_b_w),
        .obj_data(obj_data_w), .upd_done(upd_done_w), .busy(busy_w), .overrun(overrun_w)
    );

    always @(posedge clk) begin
        if (we_b) mem[addr_b] <= data_b;
        q_b <= mem[addr_b];
        if (we_b_w) mem_w[addr_b_w] <= data_b_w;
        q_b_w <= mem_w[addr_b_w];
    end

    always @(negedge clk) begin
        if (we_b) we_any_cnt++;
        if (we_b && addr_b == 16'hFF00) begin
            wr_cnt++;
            wr_last = data_b;
        end
        if (upd_done) upd_cnt++;
        if (overrun) ovr_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_tick(input bit wrap);
        @(posedge clk);
        #1;
        if (wrap) frame_tick_w = 1'b1; else frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick   = 1'b0;
        frame_tick_w = 1'b0;
    endtask

    int base_wr, base_we, base_upd, base_ovr, lat;
    logic [15:0] wrap_addr [4];

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a]   = 16'h0;
            mem_w[a] = 16'h0;
        end
        mem[16'hFF10] = 16'h0011; mem[16'hFF11] = 16'h0022;
        mem[16'hFF12] = 16'h0033; mem[16'hFF13] = 16'h0044;
        mem_w[16'hFFFE] = 16'h00A1; mem_w[16'hFFFF] = 16'h00B2;
        mem_w[16'h0000] = 16'h00C3; mem_w[16'h0001] = 16'h00D4;
        wrap_addr[0] = 16'hFFFE; wrap_addr[1] = 16'hFFFF;
        wrap_addr[2] = 16'h0000; wrap_addr[3] = 16'h0001;

        reset = 1'b1; frame_tick = 1'b0; frame_tick_w = 1'b0; btn_raw = 4'b0000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset then idle
        base_we = we_any_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("idle_addr_b", 64'(addr_b), 64'h0);
        check("idle_data_b", 64'(data_b), 64'h0);
        check("idle_we_b", 64'(we_b), 64'h0);
        check("idle_obj_data", obj_data, 64'h0);
        check("idle_flags", {60'h0, upd_done, busy, overrun, we_b_w}, 64'h0);
        check("idle_we_count", 64'(we_any_cnt - base_we), 64'h0);

        // single frame
        btn_raw = 4'b0101;
        repeat (10) @(posedge clk);
        base_wr = wr_cnt; base_upd = upd_cnt;
        pulse_tick(1'b0);
        check("frame_busy", 64'(busy), 64'h1);
        check("frame_mbox_addr", 64'(addr_b), 64'hFF00);
        check("frame_mbox_we", 64'(we_b), 64'h1);
        check("frame_mbox_data", 64'(data_b), 64'h0005);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (upd_done && lat == 0) lat = k;
        end
        check("frame_upd_latency", 64'(lat), 64'd7);
        check("frame_obj_data", obj_data, 64'h0044_0033_0022_0011);
        check("frame_upd_count", 64'(upd_cnt - base_upd), 64'd1);
        check("frame_wr_count", 64'(wr_cnt - base_wr), 64'd1);
        check("frame_mem_mbox", 64'(mem[16'hFF00]), 64'h0005);

        // bounce rejection
        btn_raw = 4'b0000;
        repeat (10) @(posedge clk);
        for (int t = 0; t < 10; t++) begin
            #1 btn_raw[0] = ~btn_raw[0];
            repeat (2) @(posedge clk);
        end
        #1 btn_raw = 4'b0000;
        base_wr = wr_cnt;
        pulse_tick(1'b0);
        repeat (12) @(posedge clk);
        #1;
        check("bounce_wr_count", 64'(wr_cnt - base_wr), 64'd1);
        check("bounce_mbox_data", 64'(wr_last), 64'h0000);

        // overrun
        base_wr = wr_cnt; base_upd = upd_cnt; base_ovr = ovr_cnt;
        pulse_tick(1'b0);
        repeat (2) @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("ovr_overrun_count", 64'(ovr_cnt - base_ovr), 64'd1);
        check("ovr_upd_count", 64'(upd_cnt - base_upd), 64'd1);
        check("ovr_wr_count", 64'(wr_cnt - base_wr), 64'd1);

        // reset mid-read
        mem[16'hFF10] = 16'h1111; mem[16'hFF11] = 16'h2222;
        mem[16'hFF12] = 16'h3333; mem[16'hFF13] = 16'h4444;
        base_upd = upd_cnt;
        pulse_tick(1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_obj_data", obj_data, 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        repeat (15) @(posedge clk);
        #1;
        check("rst_upd_count", 64'(upd_cnt - base_upd), 64'd0);
        check("rst_obj_data_late", obj_data, 64'h0);
        btn_raw = 4'b1010;
        repeat (10) @(posedge clk);
        base_upd = upd_cnt; base_wr = wr_cnt;
        pulse_tick(1'b0);
        repeat (12) @(posedge clk);
        #1;
        check("rst_next_obj_data", obj_data, 64'h4444_3333_2222_1111);
        check("rst_next_upd_count", 64'(upd_cnt - base_upd), 64'd1);
        check("rst_next_mbox_data", 64'(wr_last), 64'h000A);

        // address wrap
        pulse_tick(1'b1);
        check("wrap_mbox_addr", 64'(addr_b_w), 64'hFF00);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("wrap_addr_%0d", i), 64'(addr_b_w), 64'(wrap_addr[i]));
        end
        repeat (10) @(posedge clk);
        #1;
        check("wrap_obj_data", obj_data_w, 64'h00D4_00C3_00B2_00A1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_bridge_port_b.md
# io_bridge_port_b

Peripheral bridge that owns BRAM port B of the CPU's data memory and moves data between memory and the Pong game's I/O once per video frame. On each `frame_tick` it writes the debounced player-button state into a fixed mailbox word. It then burst-reads a block of object words (paddle and ball coordinates) written by the CPU. It presents that block atomically to the display logic. It is the only master on port B and sits between the BRAM and the VGA/controller peripherals.

## Interface
Parameters:
- `BTN_ADDR`, default 16'hFF00: BRAM word address of the button mailbox.
- `OBJ_BASE`, default 16'hFF10: first BRAM word address of the object block.
- `N_OBJ`, default 4: number of object words read per frame (1..16).
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a button change is accepted (≥1).

Ports:
- `clk` in 1: system clock. This is the block's only clock.
- `reset` in 1: reset is synchronous and active-high.
- `frame_tick` in 1: one-cycle pulse from the VGA timing at vblank start.
- `btn_raw` in 4: asynchronous button inputs, ordered {p2_down, p2_up, p1_down, p1_up}.
- `q_b` in 16: BRAM port B read data. It is valid the cycle after `addr_b` is presented.
- `addr_b` out 16: BRAM port B address.
- `data_b` out 16: BRAM port B write data.
- `we_b` out 1: BRAM port B write enable.
- `obj_data` out 16*N_OBJ: object words. Word i occupies bits [16i+15:16i].
- `upd_done` out 1: one-cycle pulse when `obj_data` has just been updated.
- `busy` out 1: high while a frame transaction is in progress.
- `overrun` out 1: one-cycle pulse when `frame_tick` arrives while `busy` is high.

## Operation
- Button path:
  - Each `btn_raw` bit goes through a 2-flop synchronizer and then a per-bit debouncer.
  - The stable bit flips only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any cycle where the input matches the stable bit clears that bit's counter.
- FSM states: IDLE, WRITE_BTN, READ, DRAIN, COMMIT.
- IDLE:
  - `frame_tick` moves the FSM to WRITE_BTN.
  - All port-B outputs are 0 while in IDLE.
- WRITE_BTN (1 cycle):
  - Drives `addr_b`=`BTN_ADDR`, `data_b`={12'b0, btn_stable}, `we_b`=1.
  - Next state is READ.
- READ (N_OBJ cycles):
  - Drives `addr_b`=`OBJ_BASE`+i for i=0..N_OBJ-1, with `we_b`=0.
  - The address sum wraps modulo 2^16.
  - `q_b` for index i is captured into shadow register i in the following cycle.
  - After the last address, the FSM moves to DRAIN.
- DRAIN (1 cycle): captures the final word.
- COMMIT (1 cycle):
  - Copies the entire shadow into `obj_data` at once and pulses `upd_done`.
  - Returns to IDLE.
- `busy`=1 in every state except IDLE.
- A `frame_tick` received in a non-IDLE state is dropped, not queued, and pulses `overrun` in the same cycle.
- A `frame_tick` in the COMMIT cycle counts as busy, so it is dropped with `overrun`.
- Reset mid-transaction:
  - The FSM returns to IDLE and the shadow is cleared.
  - `obj_data` is cleared to 0; a partial update is never visible.
  - The button mailbox write, if already done, is not undone.
- Reset values:
  - All outputs are 0.
  - Synchronizers, debouncer counters, stable bits and shadow registers are all 0.

## Timing
- `frame_tick` sampled at edge E: WRITE_BTN occupies cycle E..E+1.
- Read addresses are issued at cycles E+1 .. E+N_OBJ.
- DRAIN runs at E+N_OBJ+1. `obj_data` and `upd_done` are valid after edge E+N_OBJ+3.
- Total `busy` time is N_OBJ+3 cycles. With N_OBJ=4, that is 7 cycles.
- Button latency: a raw change held steady takes 2 sync cycles plus DEBOUNCE_CYCLES before `btn_stable` reflects it. It reaches BRAM at the next frame's WRITE_BTN.
- Port-B outputs are registered.

## Structure
- Shared package holds:
  - The FSM state enum.
  - Default address constants `BTN_ADDR` and `OBJ_BASE`.
  - Button bit-index constants.
- One sub-module, `btn_debounce`: a single-bit synchronizer plus debouncer, parameterized by `DEBOUNCE_CYCLES`, instantiated 4 times.

## Test plan
All tests run with `DEBOUNCE_CYCLES`=4 and N_OBJ=4.
- Reset then idle:
  - Stimulus: assert reset, then stay idle for 20 cycles.
  - Response: all outputs 0; `we_b` never asserts.
- Single frame:
  - Stimulus: BRAM preloaded FF10..FF13 = 0x0011, 0x0022, 0x0033, 0x0044; `btn_raw`=4'b0101 held 10 cycles; then `frame_tick`.
  - Response: write of 0x0005 to FF00; `obj_data`={0x0044,0x0033,0x0022,0x0011}; `upd_done` pulses exactly 7 cycles after tick.
- Bounce rejection:
  - Stimulus: toggle `btn_raw[0]` every 2 cycles for 20 cycles.
  - Response: stable bit stays 0, and the mailbox write is 0x0000.
- Overrun:
  - Stimulus: second `frame_tick` 3 cycles after the first.
  - Response: `overrun` pulses once; exactly one `upd_done`; exactly one write to FF00.
- Reset mid-read:
  - Stimulus: assert reset at READ index 2.
  - Response: `obj_data` is 0, `upd_done` never pulses, and the next frame completes normally.
- Address wrap:
  - Stimulus: `OBJ_BASE`=16'hFFFE.
  - Response: reads from FFFE, FFFF, 0000, 0001.
